// File: rtl/rv32_debug_host.sv
// Debug-side master for RV32core: takes run/halt/step/dump commands from a host,
// drives the core debug port and streams dumped debug words out on a valid/ready port.
module rv32_debug_host #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int SETTLE   = 1,
  parameter int STEP_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_arg,
  output logic              cmd_err,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              halted,
  output logic              busy
);

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] GAP_LAST    = (STEP_GAP > 0) ? 4'(STEP_GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_RUN,
    S_HALTED,
    S_STEP_PULSE,
    S_STEP_GAP,
    S_DUMP_SETTLE,
    S_DUMP_OUT
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] step_cnt;
  logic [ADDR_W-1:0] last_idx;
  logic [3:0]        gap_cnt;
  logic [3:0]        settle_cnt;
  logic              ret_halted;

  logic cmd_acc;
  logic step_done;
  logic gap_done;
  logic settle_done;
  logic step_adv;
  logic beat_hs;

  assign cmd_acc     = cmd_valid && cmd_ready;
  assign step_done   = (step_cnt == '0);
  assign gap_done    = (gap_cnt == GAP_LAST);
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign beat_hs     = (state == S_DUMP_OUT) && out_ready;
  assign halted      = debug_en;

  // A step finishes its gap (or its pulse, when there is no gap) and more steps remain
  assign step_adv = !step_done &&
                    (((state == S_STEP_GAP) && gap_done) ||
                     ((state == S_STEP_PULSE) && (STEP_GAP == 0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (cmd_acc) begin
          if (cmd_op == OP_HALT)      state_nxt = S_HALTED;
          else if (cmd_op == OP_DUMP) state_nxt = S_DUMP_SETTLE;
        end
      end
      S_HALTED: begin
        if (cmd_acc) begin
          case (cmd_op)
            OP_RUN:  state_nxt = S_RUN;
            OP_STEP: state_nxt = S_STEP_PULSE;
            OP_DUMP: state_nxt = S_DUMP_SETTLE;
            default: state_nxt = S_HALTED;
          endcase
        end
      end
      S_STEP_PULSE: begin
        if (STEP_GAP != 0) state_nxt = S_STEP_GAP;
        else               state_nxt = step_done ? S_HALTED : S_STEP_PULSE;
      end
      S_STEP_GAP: begin
        if (gap_done) state_nxt = step_done ? S_HALTED : S_STEP_PULSE;
      end
      S_DUMP_SETTLE: begin
        if (settle_done) state_nxt = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (out_ready) begin
          if (out_last) state_nxt = ret_halted ? S_HALTED : S_RUN;
          else          state_nxt = S_DUMP_SETTLE;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    debug_step = 1'b0;
    busy       = 1'b1;
    case (state)
      S_RUN, S_HALTED: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_STEP_PULSE: debug_step = 1'b1;
      default: ;
    endcase
  end

  // Command side: halt enable, illegal-command flag and step bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debug_en <= 1'b0;
      cmd_err  <= 1'b0;
      step_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      cmd_err <= cmd_acc && (state == S_RUN) && (cmd_op == OP_STEP);
      if (cmd_acc && (cmd_op == OP_HALT))     debug_en <= 1'b1;
      else if (cmd_acc && (cmd_op == OP_RUN)) debug_en <= 1'b0;
      if (cmd_acc && (state == S_HALTED) && (cmd_op == OP_STEP)) step_cnt <= cmd_arg;
      else if (step_adv)                                          step_cnt <= step_cnt - 1'b1;
      if (state == S_STEP_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                     gap_cnt <= '0;
    end
  end

  // Dump side: debug_addr doubles as the running dump index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debug_addr <= '0;
      last_idx   <= '0;
      ret_halted <= 1'b0;
      settle_cnt <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
    end else begin
      if (cmd_acc && (cmd_op == OP_DUMP)) begin
        debug_addr <= '0;
        last_idx   <= cmd_arg;
        ret_halted <= (state == S_HALTED);
      end
      if (state == S_DUMP_SETTLE) settle_cnt <= settle_cnt + 1'b1;
      else                        settle_cnt <= '0;
      if ((state == S_DUMP_SETTLE) && settle_done) begin
        out_data  <= debug_data;
        out_addr  <= debug_addr;
        out_valid <= 1'b1;
        out_last  <= (debug_addr == last_idx);
      end
      if (beat_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (!out_last) debug_addr <= debug_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv32_debug_host.sv
// Directed bench for rv32_debug_host: dump beats go through a queue scoreboard
// checked by an independent monitor; step/err/reset behaviour is checked inline.
module tb_rv32_debug_host;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_arg;
  logic              cmd_err;
  logic              debug_en;
  logic              debug_step;
  logic [ADDR_W-1:0] debug_addr;
  logic [DATA_W-1:0] debug_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              halted;
  logic              busy;

  logic [DATA_W-1:0] salt;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int n_checks;
  int n_fail;

  rv32_debug_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE(1), .STEP_GAP(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_err(cmd_err),
    .debug_en(debug_en), .debug_step(debug_step), .debug_addr(debug_addr),
    .debug_data(debug_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last),
    .halted(halted), .busy(busy)
  );

  // Core model: combinational read data tagged with the address
  assign debug_data = (32'hA500_0000 | 32'(debug_addr)) ^ salt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat_addr", 32'(out_addr), 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_addr", 32'(out_addr), 32'(b.addr));
        check("beat_data", out_data, b.data);
        check("beat_last", 32'(out_last), 32'(b.last));
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] arg);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(acc), 32'd1);
  endtask

  task automatic push_dump(input int last);
    for (int a = 0; a <= last; a++) begin
      beat_t b;
      b.addr = ADDR_W'(a);
      b.data = 32'hA500_0000 | 32'(a);
      b.last = (a == last);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int pulses;
    int errs;
    logic found;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = '0;
    out_ready = 1'b1;
    salt      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state after idling
    repeat (5) @(negedge clk);
    check("rst_debug_en", 32'(debug_en), 32'd0);
    check("rst_debug_step", 32'(debug_step), 32'd0);
    check("rst_debug_addr", 32'(debug_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Halt then step 3 times: pulses at cycles 0,3,6, back to HALTED at cycle 9
    send_cmd(2'b01, '0);
    @(negedge clk);
    check("halt_halted", 32'(halted), 32'd1);
    @(posedge clk); #1;
    send_cmd(2'b10, 7'd2);
    pulses = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check($sformatf("step_pulse_c%0d", c), 32'(debug_step), 32'((c % 3 == 0) && (c <= 6)));
      check($sformatf("step_busy_c%0d", c), 32'(busy), 32'(c < 9));
      check($sformatf("step_ready_c%0d", c), 32'(cmd_ready), 32'(c >= 9));
      check($sformatf("step_en_c%0d", c), 32'(debug_en), 32'd1);
      if (debug_step) pulses++;
    end
    check("step_pulse_count", 32'(pulses), 32'd3);
    @(posedge clk); #1;

    // Back to RUN, then an illegal STEP
    send_cmd(2'b00, '0);
    @(negedge clk);
    check("run_halted", 32'(halted), 32'd0);
    @(posedge clk); #1;
    send_cmd(2'b10, 7'd0);
    errs = 0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cmd_err) errs++;
      if (debug_step) pulses++;
    end
    check("illegal_err_cycles", 32'(errs), 32'd1);
    check("illegal_no_step", 32'(pulses), 32'd0);
    check("illegal_stays_run", 32'(cmd_ready && !halted && !busy), 32'd1);
    @(posedge clk); #1;

    // Halted dump of 4 entries with out_ready high
    send_cmd(2'b01, '0);
    push_dump(3);
    send_cmd(2'b11, 7'd3);
    wait_drain("dump4_drain", 100);
    repeat (2) @(negedge clk);
    check("dump4_ready", 32'(cmd_ready), 32'd1);
    check("dump4_halted", 32'(halted), 32'd1);
    @(posedge clk); #1;

    // Stall beat 0 for 10 cycles while the core data changes under it
    out_ready = 1'b0;
    push_dump(1);
    send_cmd(2'b11, 7'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = out_valid;
    end
    check("stall_valid_seen", 32'(found), 32'd1);
    salt = 32'h0000_FF00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("stall_valid_c%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("stall_addr_c%0d", c), 32'(out_addr), 32'd0);
      check($sformatf("stall_data_c%0d", c), out_data, 32'hA500_0000);
    end
    salt = '0;
    out_ready = 1'b1;
    wait_drain("stall_drain", 100);
    @(posedge clk); #1;

    // Full 128-entry dump, then a few idle cycles with no stray beat
    push_dump(127);
    send_cmd(2'b11, 7'd127);
    wait_drain("dump128_drain", 1000);
    repeat (10) @(negedge clk);
    check("dump128_no_extra", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Second full dump, reset asynchronously at beat 40
    push_dump(127);
    send_cmd(2'b11, 7'd127);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      found = out_valid && (out_addr == 7'd40);
    end
    check("beat40_seen", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_debug_en", 32'(debug_en), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_debug_addr", 32'(debug_addr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_debug_host.md
Name: rv32_debug_host

Overview:
- Debug-side master that drives the core's debug port (debug_en, debug_step, debug_addr) and reads back debug_data.
- Accepts single commands (run, halt, step, dump) from a host, e.g. a UART bridge or a test bench.
- Returns dumped register/debug words on a valid/ready output stream.
- Sits between the host interface and RV32core, replacing the tie-offs used in simulation.

Parameters:
- ADDR_W, 7, width of debug_addr and of the dump index.
- DATA_W, 32, width of debug_data and out_data.
- SETTLE, 1, cycles to wait after changing debug_addr before sampling debug_data (1..15).
- STEP_GAP, 2, idle cycles after each debug_step pulse before the next command is accepted (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  command: 00 RUN, 01 HALT, 10 STEP, 11 DUMP.
- cmd_arg  in  ADDR_W  for DUMP: last address, inclusive. For STEP: step count minus 1. Ignored otherwise.
- cmd_err  out  1  one-cycle pulse when a command is illegal in the current state.
- debug_en  out  1  core debug/halt enable.
- debug_step  out  1  single-cycle step pulse to the core.
- debug_addr  out  ADDR_W  debug read address to the core.
- debug_data  in  DATA_W  combinational read data from the core.
- out_valid  out  1  dump beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_addr  out  ADDR_W  address of the current beat.
- out_data  out  DATA_W  captured debug_data.
- out_last  out  1  high on the final beat of a dump.
- halted  out  1  mirrors debug_en.
- busy  out  1  high in any state other than RUN or HALTED.

Behaviour:
- Reset (asynchronous, any state, including mid-step or mid-dump):
  - state=RUN; debug_en=0, debug_step=0, debug_addr=0.
  - out_valid=0, out_last=0, out_addr=0, out_data=0, cmd_err=0.
  - halted=0, busy=0.
  - A pending out beat is dropped, not completed.
- States: RUN, HALTED, STEP_PULSE, STEP_GAP, DUMP_SETTLE, DUMP_OUT.
- cmd_ready=1 only in RUN and HALTED (combinational from state).
- RUN:
  - HALT -> HALTED, debug_en=1 from the next cycle.
  - RUN -> no-op.
  - DUMP -> DUMP_SETTLE.
  - STEP -> illegal: cmd_err pulses for 1 cycle, state unchanged.
- HALTED:
  - RUN -> RUN, debug_en=0 from the next cycle.
  - HALT -> no-op.
  - STEP -> load step counter = cmd_arg, go to STEP_PULSE.
  - DUMP -> DUMP_SETTLE.
- STEP_PULSE: debug_step=1 for exactly one cycle, then STEP_GAP.
- STEP_GAP:
  - Wait STEP_GAP cycles with debug_step=0.
  - If counter==0, go to HALTED; else decrement and go to STEP_PULSE.
  - cmd_arg=N therefore gives N+1 pulses, spaced 1+STEP_GAP cycles apart.
- DUMP:
  - On accept: index=0, last=cmd_arg, debug_addr=0.
  - DUMP_SETTLE: wait SETTLE cycles, then register out_data=debug_data and out_addr=index, set out_valid=1 and out_last=(index==last), go to DUMP_OUT.
  - DUMP_OUT: hold out_valid, out_data, out_addr and out_last stable until out_ready.
  - On the handshake cycle:
    - If last: out_valid=0, return to the state the dump began in (RUN or HALTED).
    - Else: index+1, debug_addr=index+1, out_valid=0, go to DUMP_SETTLE.
  - No back-to-back beats: minimum beat spacing is SETTLE+1 cycles.
- debug_en does not change during a dump. A dump while RUN samples live, non-coherent data; this is legal.
- Index wrap: cmd_arg=2^ADDR_W-1 dumps all 128 entries. Termination is by equality, so the index never wraps to 0 and re-reads.
- out_ready held high: each beat completes on its first valid cycle.
- out_ready low: the FSM stalls indefinitely. debug_addr holds and debug_data is not re-sampled.
- cmd_valid while busy is ignored and must be held by the host, per valid/ready.
- cmd_err is registered and never asserts together with a cmd_ready acceptance of the same command.

Test Plan:
- Reset, then idle 5 cycles -> debug_en=0, debug_step=0, debug_addr=0, out_valid=0, cmd_ready=1, halted=0.
- HALT, then STEP cmd_arg=2 (STEP_GAP=2) -> exactly 3 one-cycle debug_step pulses, 3 cycles apart. busy high throughout, cmd_ready=0 until return to HALTED. debug_en=1 throughout.
- STEP issued in RUN -> cmd_err high for exactly 1 cycle, no debug_step pulse, state stays RUN.
- HALT, then DUMP cmd_arg=3, core model returns data=0xA500_0000|addr, out_ready=1 -> 4 beats with (addr, data) = (0, 0xA5000000) .. (3, 0xA5000003). out_last only on addr 3. Then back to HALTED with debug_en=1.
- DUMP cmd_arg=1 with out_ready low for 10 cycles on beat 0 -> out_valid, out_addr=0 and out_data stay stable for all 10 cycles, then the dump completes normally.
- DUMP cmd_arg=127 -> exactly 128 beats, last beat out_addr=127 with out_last=1, no beat with addr 0 after it. Then assert rst during a second dump at beat 40 -> out_valid=0, debug_en=0, state RUN immediately, without waiting for a clock edge.
